frame_draw_scheduler: RTL and testbench

//  Sequences all VGA pixel writes for one game frame and is the sole driver of vga_adapter x/y/colour/plot.
//  Per frame tick it erases the player and obstacle at their last drawn positions.
//  It then pulses update so the game logic moves its objects, latches the new positions, and redraws both sprites.
//  One pixel is issued per clock, so the game datapath never drives the VGA port directly.

---
 rtl/frame_draw_scheduler.sv | 270 +++++++++++++++++++++++++++
 tb/tb_frame_draw_scheduler.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_draw_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : frame_draw_scheduler
// Description : Per-frame pixel sequencer and the only source of pixel writes
//               into the VGA adapter. On every frame tick it erases the player
//               and the obstacle at the positions they were last drawn, pulses
//               update so the game logic can move its objects, latches the new
//               positions/colours and redraws both sprites, one pixel per
//               clock.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   SIZE       sprite edge length in pixels (square sprites, 1..15)
//   X_MAX      last visible column; pixels beyond it are not plotted
//   Y_MAX      last visible row; pixels beyond it are not plotted
//   BG_COLOUR  colour written when erasing
// Ports
//   clock_i         system clock
//   reset_i         asynchronous active-high reset
//   frame_tick_i    one-cycle frame request
//   player_x_i/y_i  player top-left corner   (sampled in LATCH only)
//   player_col_i    player colour            (sampled in LATCH only)
//   obstacle_x_i/y_i obstacle top-left corner (sampled in LATCH only)
//   obstacle_col_i  obstacle colour          (sampled in LATCH only)
//   x_o, y_o        registered pixel coordinate
//   colour_o        registered pixel colour
//   plot_o          registered pixel write enable
//   update_o        one-cycle pulse: game objects may move now
//   busy_o          high whenever the sequencer is not idle
//   frame_done_o    one-cycle pulse at the end of a frame
//   overrun_o       sticky flag: a tick arrived while a frame was in progress
// ============================================================================
module frame_draw_scheduler #(
   parameter int         SIZE      = 4,
   parameter int         X_MAX     = 159,
   parameter int         Y_MAX     = 119,
   parameter logic [2:0] BG_COLOUR = 3'b000
) (
   input  logic       clock_i,
   input  logic       reset_i,
   input  logic       frame_tick_i,
   input  logic [7:0] player_x_i,
   input  logic [6:0] player_y_i,
   input  logic [2:0] player_col_i,
   input  logic [7:0] obstacle_x_i,
   input  logic [6:0] obstacle_y_i,
   input  logic [2:0] obstacle_col_i,
   output logic [7:0] x_o,
   output logic [6:0] y_o,
   output logic [2:0] colour_o,
   output logic       plot_o,
   output logic       update_o,
   output logic       busy_o,
   output logic       frame_done_o,
   output logic       overrun_o
);

   // Offset counters are 4 bits wide, which covers the largest legal SIZE.
   localparam logic [3:0] c_LAST  = 4'(SIZE - 1);
   localparam logic [8:0] c_X_MAX = 9'(X_MAX);
   localparam logic [7:0] c_Y_MAX = 8'(Y_MAX);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ERASE_P = 3'd1,
      ERASE_O = 3'd2,
      UPDATE  = 3'd3,
      LATCH   = 3'd4,
      DRAW_P  = 3'd5,
      DRAW_O  = 3'd6,
      DONE    = 3'd7
   } state_t;

   state_t     state_q;
   logic [3:0] dx_q;
   logic [3:0] dy_q;
   logic       drawn_q;
   logic       overrun_q;

   // Positions/colours of the sprites as last latched (i.e. as drawn).
   logic [7:0] p_x_q;
   logic [6:0] p_y_q;
   logic [2:0] p_col_q;
   logic [7:0] o_x_q;
   logic [6:0] o_y_q;
   logic [2:0] o_col_q;

   // Registered VGA-side outputs.
   logic [7:0] x_q;
   logic [6:0] y_q;
   logic [2:0] colour_q;
   logic       plot_q;
   logic       update_q;
   logic       frame_done_q;

   // Pixel that the current sweep state will emit on the next edge.
   logic [7:0] base_x_d;
   logic [6:0] base_y_d;
   logic [2:0] pix_col_d;
   logic       pix_en_d;
   logic [8:0] sum_x_d;
   logic [7:0] sum_y_d;
   logic       pix_plot_d;
   logic       sweep_last_d;

   // ------------------------------------------------------------------------
   // Sprite/pixel selection for the sweep phases
   // ------------------------------------------------------------------------
   always_comb begin
      base_x_d  = p_x_q;
      base_y_d  = p_y_q;
      pix_col_d = BG_COLOUR;
      pix_en_d  = 1'b0;
      case (state_q)
         ERASE_P: begin
            base_x_d  = p_x_q;
            base_y_d  = p_y_q;
            pix_col_d = BG_COLOUR;
            // Nothing has been drawn since reset, so there is nothing to erase.
            pix_en_d  = drawn_q;
         end
         ERASE_O: begin
            base_x_d  = o_x_q;
            base_y_d  = o_y_q;
            pix_col_d = BG_COLOUR;
            pix_en_d  = drawn_q;
         end
         DRAW_P: begin
            base_x_d  = p_x_q;
            base_y_d  = p_y_q;
            pix_col_d = p_col_q;
            pix_en_d  = 1'b1;
         end
         DRAW_O: begin
            base_x_d  = o_x_q;
            base_y_d  = o_y_q;
            pix_col_d = o_col_q;
            pix_en_d  = 1'b1;
         end
         default: begin
            base_x_d  = p_x_q;
            base_y_d  = p_y_q;
            pix_col_d = BG_COLOUR;
            pix_en_d  = 1'b0;
         end
      endcase

      // One extra bit on each axis so sprites hanging off the right/bottom
      // edge are clipped instead of wrapping back onto the screen.
      sum_x_d      = {1'b0, base_x_d} + {5'b0, dx_q};
      sum_y_d      = {1'b0, base_y_d} + {4'b0, dy_q};
      pix_plot_d   = pix_en_d && (sum_x_d <= c_X_MAX) && (sum_y_d <= c_Y_MAX);
      sweep_last_d = (dx_q == c_LAST) && (dy_q == c_LAST);
   end

   // ------------------------------------------------------------------------
   // Frame sequencer. Outputs are registered alongside the state, so each
   // state's outputs become visible one clock after the state is entered.
   // ------------------------------------------------------------------------
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q      <= IDLE;
         dx_q         <= 4'd0;
         dy_q         <= 4'd0;
         drawn_q      <= 1'b0;
         overrun_q    <= 1'b0;
         p_x_q        <= 8'd0;
         p_y_q        <= 7'd0;
         p_col_q      <= 3'd0;
         o_x_q        <= 8'd0;
         o_y_q        <= 7'd0;
         o_col_q      <= 3'd0;
         x_q          <= 8'd0;
         y_q          <= 7'd0;
         colour_q     <= 3'd0;
         plot_q       <= 1'b0;
         update_q     <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         // Pulse outputs default low; only the owning state raises them.
         plot_q       <= 1'b0;
         update_q     <= 1'b0;
         frame_done_q <= 1'b0;

         // IDLE and DONE are the only states that accept a tick.
         if (frame_tick_i && (state_q != IDLE) && (state_q != DONE)) begin
            overrun_q <= 1'b1;
         end

         case (state_q)
            IDLE: begin
               if (frame_tick_i) begin
                  state_q <= ERASE_P;
                  dx_q    <= 4'd0;
                  dy_q    <= 4'd0;
               end
            end

            ERASE_P, ERASE_O, DRAW_P, DRAW_O: begin
               // Off-screen pixels still present their truncated coordinate.
               x_q      <= sum_x_d[7:0];
               y_q      <= sum_y_d[6:0];
               colour_q <= pix_col_d;
               plot_q   <= pix_plot_d;

               if (sweep_last_d) begin
                  dx_q <= 4'd0;
                  dy_q <= 4'd0;
                  case (state_q)
                     ERASE_P: state_q <= ERASE_O;
                     ERASE_O: state_q <= UPDATE;
                     DRAW_P:  state_q <= DRAW_O;
                     default: state_q <= DONE;
                  endcase
               end else if (dx_q == c_LAST) begin
                  dx_q <= 4'd0;
                  dy_q <= dy_q + 4'd1;
               end else begin
                  dx_q <= dx_q + 4'd1;
               end
            end

            UPDATE: begin
               update_q <= 1'b1;
               state_q  <= LATCH;
            end

            LATCH: begin
               p_x_q   <= player_x_i;
               p_y_q   <= player_y_i;
               p_col_q <= player_col_i;
               o_x_q   <= obstacle_x_i;
               o_y_q   <= obstacle_y_i;
               o_col_q <= obstacle_col_i;
               dx_q    <= 4'd0;
               dy_q    <= 4'd0;
               state_q <= DRAW_P;
            end

            DONE: begin
               frame_done_q <= 1'b1;
               drawn_q      <= 1'b1;
               // A tick landing exactly here chains straight into a new frame.
               if (frame_tick_i) begin
                  state_q <= ERASE_P;
                  dx_q    <= 4'd0;
                  dy_q    <= 4'd0;
               end else begin
                  state_q <= IDLE;
               end
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign x_o          = x_q;
   assign y_o          = y_q;
   assign colour_o     = colour_q;
   assign plot_o       = plot_q;
   assign update_o     = update_q;
   assign frame_done_o = frame_done_q;
   assign overrun_o    = overrun_q;
   assign busy_o       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_frame_draw_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_draw_scheduler
// Description : Directed self-checking bench for frame_draw_scheduler.
//               Cycle numbering: the edge that samples the frame tick is
//               cycle 0; outputs registered on edge k are observed 1 ns later
//               and called cycle k.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_draw_scheduler;

   logic       clock_i = 1'b0;
   logic       reset_i = 1'b1;
   logic       frame_tick_i = 1'b0;
   logic [7:0] player_x_i = 8'd0;
   logic [6:0] player_y_i = 7'd0;
   logic [2:0] player_col_i = 3'd0;
   logic [7:0] obstacle_x_i = 8'd0;
   logic [6:0] obstacle_y_i = 7'd0;
   logic [2:0] obstacle_col_i = 3'd0;
   logic [7:0] x_o;
   logic [6:0] y_o;
   logic [2:0] colour_o;
   logic       plot_o;
   logic       update_o;
   logic       busy_o;
   logic       frame_done_o;
   logic       overrun_o;

   int checks = 0;
   int errors = 0;
   logic exp_ovr = 1'b0;
   int cnt_ep, cnt_eo, cnt_dp, cnt_do;

   frame_draw_scheduler #(
      .SIZE      (4),
      .X_MAX     (159),
      .Y_MAX     (119),
      .BG_COLOUR (3'b000)
   ) dut (
      .clock_i        (clock_i),
      .reset_i        (reset_i),
      .frame_tick_i   (frame_tick_i),
      .player_x_i     (player_x_i),
      .player_y_i     (player_y_i),
      .player_col_i   (player_col_i),
      .obstacle_x_i   (obstacle_x_i),
      .obstacle_y_i   (obstacle_y_i),
      .obstacle_col_i (obstacle_col_i),
      .x_o            (x_o),
      .y_o            (y_o),
      .colour_o       (colour_o),
      .plot_o         (plot_o),
      .update_o       (update_o),
      .busy_o         (busy_o),
      .frame_done_o   (frame_done_o),
      .overrun_o      (overrun_o)
   );

   always #5 clock_i = ~clock_i;

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " x"},          16'(x_o),          16'd0);
      chk({tag, " y"},          16'(y_o),          16'd0);
      chk({tag, " colour"},     16'(colour_o),     16'd0);
      chk({tag, " plot"},       16'(plot_o),       16'd0);
      chk({tag, " update"},     16'(update_o),     16'd0);
      chk({tag, " busy"},       16'(busy_o),       16'd0);
      chk({tag, " frame_done"}, 16'(frame_done_o), 16'd0);
      chk({tag, " overrun"},    16'(overrun_o),    16'd0);
   endtask

   // Called 1 ns after an edge while idle: issues the tick sampled at cycle 0.
   task automatic start_frame();
      frame_tick_i = 1'b1;
      @(posedge clock_i);
      #1;
      frame_tick_i = 1'b0;
      chk("c0 busy", 16'(busy_o), 16'd1);
      chk("c0 plot", 16'(plot_o), 16'd0);
   endtask

   // Walks cycles 1..last of one frame with SIZE=4 and checks every output.
   // tick_a/tick_b (0 = unused) raise frame_tick for the edge of that cycle.
   task automatic run_frame(
      input int opx, input int opy, input int oox, input int ooy, input logic odrawn,
      input int npx, input int npy, input int npc,
      input int nox, input int noy, input int noc,
      input int tick_a, input int tick_b, input int last);
      int bx, by, ecol, i, sx, sy;
      logic en, sweep, e_plot, e_upd, e_done, e_busy;
      cnt_ep = 0; cnt_eo = 0; cnt_dp = 0; cnt_do = 0;
      for (int c = 1; c <= last; c++) begin
         frame_tick_i = (c == tick_a) || (c == tick_b);
         @(posedge clock_i);
         #1;
         frame_tick_i = 1'b0;
         if (((c == tick_a) || (c == tick_b)) && (c < 67)) exp_ovr = 1'b1;
         sweep = 1'b0; e_upd = 1'b0; e_done = 1'b0; en = 1'b0;
         bx = 0; by = 0; ecol = 0; i = 0;
         if (c <= 16) begin
            sweep = 1'b1; i = c - 1;  bx = opx; by = opy; ecol = 0; en = odrawn;
         end else if (c <= 32) begin
            sweep = 1'b1; i = c - 17; bx = oox; by = ooy; ecol = 0; en = odrawn;
         end else if (c == 33) begin
            e_upd = 1'b1;
         end else if (c == 34) begin
            e_upd = 1'b0;
         end else if (c <= 50) begin
            sweep = 1'b1; i = c - 35; bx = npx; by = npy; ecol = npc; en = 1'b1;
         end else if (c <= 66) begin
            sweep = 1'b1; i = c - 51; bx = nox; by = noy; ecol = noc; en = 1'b1;
         end else begin
            e_done = 1'b1;
         end
         e_plot = 1'b0;
         if (sweep) begin
            sx = bx + (i % 4);
            sy = by + (i / 4);
            e_plot = en && (sx <= 159) && (sy <= 119);
            chk($sformatf("c%0d x", c),      16'(x_o),      16'(sx[7:0]));
            chk($sformatf("c%0d y", c),      16'(y_o),      16'(sy[6:0]));
            chk($sformatf("c%0d colour", c), 16'(colour_o), 16'(ecol[2:0]));
         end
         e_busy = (c < 67) || (c == tick_b) || (c == tick_a);
         chk($sformatf("c%0d plot", c),       16'(plot_o),       16'(e_plot));
         chk($sformatf("c%0d update", c),     16'(update_o),     16'(e_upd));
         chk($sformatf("c%0d frame_done", c), 16'(frame_done_o), 16'(e_done));
         chk($sformatf("c%0d busy", c),       16'(busy_o),       16'(e_busy));
         chk($sformatf("c%0d overrun", c),    16'(overrun_o),    16'(exp_ovr));
         if (plot_o === 1'b1) begin
            if (c <= 16) cnt_ep++;
            else if (c <= 32) cnt_eo++;
            else if (c <= 50) cnt_dp++;
            else cnt_do++;
         end
      end
   endtask

   initial begin
      // Reset
      repeat (2) @(posedge clock_i);
      #1;
      chk_all_zero("reset");
      reset_i = 1'b0;
      @(posedge clock_i);
      #1;
      chk_all_zero("idle");

      // Frame A: first frame after reset, erase is suppressed.
      player_x_i = 8'd20;    player_y_i = 7'd60;    player_col_i = 3'b100;
      obstacle_x_i = 8'd150; obstacle_y_i = 7'd100; obstacle_col_i = 3'b001;
      start_frame();
      run_frame(0, 0, 0, 0, 1'b0, 20, 60, 4, 150, 100, 1, 0, 0, 67);
      chk("A erase plots", 16'(cnt_ep + cnt_eo), 16'd0);
      chk("A draw_p plots", 16'(cnt_dp), 16'd16);
      chk("A draw_o plots", 16'(cnt_do), 16'd16);
      @(posedge clock_i);
      #1;
      chk("A idle busy", 16'(busy_o), 16'd0);
      chk("A idle done", 16'(frame_done_o), 16'd0);

      // Frame B: player moves up, obstacle at the corner, tick at cycle 10
      // (overrun) and tick in DONE (back-to-back).
      player_x_i = 8'd20;    player_y_i = 7'd58;
      obstacle_x_i = 8'd158; obstacle_y_i = 7'd118; obstacle_col_i = 3'b001;
      start_frame();
      run_frame(20, 60, 150, 100, 1'b1, 20, 58, 4, 158, 118, 1, 10, 67, 67);
      chk("B erase_p plots", 16'(cnt_ep), 16'd16);
      chk("B draw_o clipped plots", 16'(cnt_do), 16'd4);
      chk("B overrun", 16'(overrun_o), 16'd1);

      // Frame C: chained from B's DONE; erases the clipped obstacle.
      player_x_i = 8'd30;  player_y_i = 7'd40; player_col_i = 3'b010;
      obstacle_x_i = 8'd0; obstacle_y_i = 7'd0; obstacle_col_i = 3'b111;
      run_frame(20, 58, 158, 118, 1'b1, 30, 40, 2, 0, 0, 7, 0, 0, 67);
      chk("C erase_o clipped plots", 16'(cnt_eo), 16'd4);
      chk("C overrun sticky", 16'(overrun_o), 16'd1);
      @(posedge clock_i);
      #1;
      chk("C idle busy", 16'(busy_o), 16'd0);

      // Frame D: reset asserted during DRAW_P on cycle 40.
      player_x_i = 8'd100; player_y_i = 7'd10; player_col_i = 3'b101;
      obstacle_x_i = 8'd60; obstacle_y_i = 7'd70; obstacle_col_i = 3'b110;
      start_frame();
      run_frame(30, 40, 0, 0, 1'b1, 100, 10, 5, 60, 70, 6, 0, 0, 39);
      chk("D plot before reset", 16'(plot_o), 16'd1);
      #2;
      reset_i = 1'b1;
      exp_ovr = 1'b0;
      #1;
      chk_all_zero("midreset");
      @(posedge clock_i);
      #1;
      reset_i = 1'b0;
      chk_all_zero("after reset");

      // Frame E: drawn was cleared, so erase is suppressed again.
      player_x_i = 8'd5;    player_y_i = 7'd5;  player_col_i = 3'b011;
      obstacle_x_i = 8'd140; obstacle_y_i = 7'd50; obstacle_col_i = 3'b010;
      start_frame();
      run_frame(0, 0, 0, 0, 1'b0, 5, 5, 3, 140, 50, 2, 0, 0, 67);
      chk("E erase plots", 16'(cnt_ep + cnt_eo), 16'd0);
      chk("E draw plots", 16'(cnt_dp + cnt_do), 16'd32);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
